axis_bram_adapter_v1_0_rowbuf: RTL and testbench
================================================

# axis_bram_adapter_v1_0_rowbuf

Row-buffer datapath of the AXIS↔BRAM adapter, driven by `axis_bram_adapter_v1_0_cntl`. It holds one BRAM row of `BRAM_WIDTH_IN_WORD` words, and applies the controller's per-word mux codes every cycle. In write mode it assembles stream words into a row for `bram_din`. In read mode it loads a whole row from `bram_dout` and drives the selected word onto the output stream. It also tracks which words of the row under assembly hold fresh stream data, and flags BRAM writes of incomplete rows.

## Interface
Parameters:
- `WORD_WIDTH`, 16, width of one stream word.
- `BRAM_WIDTH_IN_WORD`, 36, words per BRAM row (N).
- `TO_AXIS_MUX_CNTL_BITS`, 6, width of the output word select.

Ports:
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: reset, asynchronous assert, active-low.
- `from_axis_mux_cntl` in 2N: per-word load code; bits [2i+1:2i] control word i.
- `to_axis_mux_cntl` in `TO_AXIS_MUX_CNTL_BITS`: output word select.
- `bram_wen` in 1: BRAM write strobe from the controller.
- `s_axis_tdata` in `WORD_WIDTH`: input stream data.
- `s_axis_tvalid` in 1: input stream valid; qualifies fill tracking only.
- `bram_dout` in N*`WORD_WIDTH`: BRAM read data; word i is at bits [(i+1)W-1:iW].
- `bram_din` out N*`WORD_WIDTH`: row register, with the same packing as `bram_dout`.
- `m_axis_tdata` out `WORD_WIDTH`: selected output word.
- `row_complete` out 1: all N fill bits are set.
- `underfill_err` out 1: sticky flag, set when a BRAM write occurs while the row is incomplete.

## Operation
- Row register `row_q[0..N-1]`, each word `WORD_WIDTH` wide. Reset value 0.
- Per-word code `c_i = from_axis_mux_cntl[2i+1:2i]`:
  - `c_i[1]=0`: word i holds its value.
  - `c_i = 2'b11`: word i loads `s_axis_tdata`.
  - `c_i = 2'b10`: word i loads word i of `bram_dout`.
- All N words update independently in the same cycle. Multiple words loading at once is legal; `all-10` is the normal whole-row read load.
- `bram_din = row_q`. There is no extra register on `bram_din`.
- `m_axis_tdata = row_q[to_axis_mux_cntl]`. This path is combinational.
  - If `to_axis_mux_cntl >= N`, `m_axis_tdata` is 0. It must never be X.
- Fill mask `fill_q[N-1:0]`, reset value 0. Per bit i, the next value is computed as follows:
  - Set term: 1 if `c_i=11` and `s_axis_tvalid`.
  - Load term: 1 if `c_i=10`; a BRAM row is complete by definition.
  - Hold term: `fill_q[i]` if `c_i[1]=0`. When `c_i=11` and `!s_axis_tvalid`, the bit is cleared to 0, because the word is being overwritten with invalid data.
  - If `bram_wen=1`, the hold term is forced to 0, so the mask restarts. Set and load terms from the same cycle still apply: the first word of the next row may arrive in the write cycle.
- `row_complete = &fill_q`, combinational from the register.
- `underfill_err`: reset 0. It is set at the clock edge where `bram_wen=1` and `row_complete=0`, using the mask before that edge's clear. It stays set until reset.

## Timing
- Row load latency: a code applied in cycle t makes the new word visible on `bram_din` and `m_axis_tdata` in cycle t+1.
- Write path: the controller's final-word handshake at cnt=N-1 loads word N-1 at edge t. `bram_wen` is asserted in cycle t+1, when `bram_din` already holds the full row and `row_complete=1`.
- Read path: a row read issued via `bram_en` appears on `bram_dout` one BRAM latency later. The controller presents code `10` only in the cycle the data is valid, so the rowbuf adds no wait states.
- Reset mid-operation: all registers clear asynchronously on `rstn` fall. `m_axis_tdata` then follows `row_q=0`. Release is synchronous to `clk`, so the first update happens on the edge after `rstn` rises.
- All outputs are 0 during reset, including `row_complete`.

## Structure
- Shared package `axis_bram_adapter_v1_0_pkg` holds:
  - Code constants `MUX_HOLD=2'b00`, `MUX_AXIS=2'b11`, `MUX_BRAM=2'b10`.
  - Default `BRAM_WIDTH_IN_WORD` and `WORD_WIDTH`.
- One natural sub-module, `axis_bram_adapter_v1_0_wordslot`. It contains one word register plus its fill bit and is instantiated N times via generate.
- The top level holds the output mux, `row_complete` and `underfill_err`.

## Test plan
- Reset, then drive sel=5 with all codes 00 → `m_axis_tdata=0`, `bram_din=0`, `row_complete=0`, `underfill_err=0`.
- Write row: for i=0..35, drive code 11 on word i with tvalid=1 and data 0x100+i → `bram_din` word 35 = 0x123, `row_complete=1`. Pulse `bram_wen` → `underfill_err` stays 0 and mask returns to 0.
- Underfill: load words 0..9 only, then pulse `bram_wen` → `underfill_err=1`, and it remains 1 after 10 more idle cycles.
- Read row: `bram_dout` word i = 0xA000+i, all codes 10 for one cycle, then step sel 0..35 → `m_axis_tdata` = 0xA000..0xA023. sel=40 → 0.
- Stall: code 11 on word 3 with tvalid=0, data 0xDEAD → word 3 = 0xDEAD and `fill_q[3]=0`. Raise tvalid with 0xBEEF → `fill_q[3]=1`.
- Async reset with a half-filled row mid-cycle → all outputs 0 immediately. The next row starts from an empty mask.

Source files
------------

// File: rtl/axis_bram_adapter_v1_0_pkg.sv
// Shared definitions for the AXIS<->BRAM adapter.
//   MUX_*    : per-word load codes driven by the controller into the row buffer
//   DEFAULT_*: default geometry of one BRAM row
package axis_bram_adapter_v1_0_pkg;

    localparam logic [1:0] MUX_HOLD = 2'b00;
    localparam logic [1:0] MUX_AXIS = 2'b11;
    localparam logic [1:0] MUX_BRAM = 2'b10;

    localparam int unsigned DEFAULT_BRAM_WIDTH_IN_WORD = 36;
    localparam int unsigned DEFAULT_WORD_WIDTH         = 16;

endpackage

// File: rtl/axis_bram_adapter_v1_0_wordslot.sv
// One word of the row buffer plus its fill bit.
//   clk, rstn       : clock, async active-low reset
//   code            : 2-bit load code for this word (hold / stream / BRAM)
//   s_axis_tdata    : stream word
//   s_axis_tvalid   : stream valid, qualifies the fill bit only
//   bram_word       : this word's slice of the BRAM read row
//   bram_wen        : BRAM write strobe, restarts the fill mask
//   word            : registered word value
//   fill            : registered fill bit (word holds fresh valid data)
module axis_bram_adapter_v1_0_wordslot
    import axis_bram_adapter_v1_0_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [1:0]            code,
    input  logic [WORD_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic [WORD_WIDTH-1:0] bram_word,
    input  logic                  bram_wen,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  fill
);

    logic [WORD_WIDTH-1:0] word_d;
    logic                  fill_d;

    always_comb begin
        word_d = word;
        if (code == MUX_AXIS) begin
            word_d = s_axis_tdata;
        end else if (code == MUX_BRAM) begin
            word_d = bram_word;
        end
    end

    // A BRAM-loaded row is complete by definition. A stream load without valid
    // clears the bit. The hold term is dropped on a BRAM write so the mask
    // restarts, while same-cycle loads still count toward the next row.
    always_comb begin
        fill_d = ((code == MUX_AXIS) && s_axis_tvalid)
               || (code == MUX_BRAM)
               || (!code[1] && fill && !bram_wen);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word <= '0;
            fill <= 1'b0;
        end else begin
            word <= word_d;
            fill <= fill_d;
        end
    end

endmodule

// File: rtl/axis_bram_adapter_v1_0_rowbuf.sv
// Row-buffer datapath of the AXIS<->BRAM adapter.
//   clk, rstn           : clock, async active-low reset
//   from_axis_mux_cntl  : per-word load codes, bits [2i+1:2i] for word i
//   to_axis_mux_cntl    : output word select
//   bram_wen            : BRAM write strobe
//   s_axis_tdata/tvalid : input stream
//   bram_dout           : BRAM read row, word i at [(i+1)W-1:iW]
//   bram_din            : row register, same packing as bram_dout
//   m_axis_tdata        : selected row word, 0 for an out-of-range select
//   row_complete        : every word of the row holds fresh data
//   underfill_err       : sticky, BRAM write of an incomplete row
module axis_bram_adapter_v1_0_rowbuf
    import axis_bram_adapter_v1_0_pkg::*;
#(
    parameter int unsigned WORD_WIDTH            = DEFAULT_WORD_WIDTH,
    parameter int unsigned BRAM_WIDTH_IN_WORD    = DEFAULT_BRAM_WIDTH_IN_WORD,
    parameter int unsigned TO_AXIS_MUX_CNTL_BITS = 6
) (
    input  logic                                     clk,
    input  logic                                     rstn,
    input  logic [2*BRAM_WIDTH_IN_WORD-1:0]          from_axis_mux_cntl,
    input  logic [TO_AXIS_MUX_CNTL_BITS-1:0]         to_axis_mux_cntl,
    input  logic                                     bram_wen,
    input  logic [WORD_WIDTH-1:0]                    s_axis_tdata,
    input  logic                                     s_axis_tvalid,
    input  logic [BRAM_WIDTH_IN_WORD*WORD_WIDTH-1:0] bram_dout,
    output logic [BRAM_WIDTH_IN_WORD*WORD_WIDTH-1:0] bram_din,
    output logic [WORD_WIDTH-1:0]                    m_axis_tdata,
    output logic                                     row_complete,
    output logic                                     underfill_err
);

    logic [BRAM_WIDTH_IN_WORD-1:0] fill;

    for (genvar i = 0; i < BRAM_WIDTH_IN_WORD; i++) begin : g_slot
        axis_bram_adapter_v1_0_wordslot #(
            .WORD_WIDTH(WORD_WIDTH)
        ) u_slot (
            .clk           (clk),
            .rstn          (rstn),
            .code          (from_axis_mux_cntl[2*i +: 2]),
            .s_axis_tdata  (s_axis_tdata),
            .s_axis_tvalid (s_axis_tvalid),
            .bram_word     (bram_dout[i*WORD_WIDTH +: WORD_WIDTH]),
            .bram_wen      (bram_wen),
            .word          (bram_din[i*WORD_WIDTH +: WORD_WIDTH]),
            .fill          (fill[i])
        );
    end

    // Decoded compare instead of an indexed read so a select past the last
    // word yields 0 rather than X.
    always_comb begin
        m_axis_tdata = '0;
        for (int i = 0; i < BRAM_WIDTH_IN_WORD; i++) begin
            if (to_axis_mux_cntl == TO_AXIS_MUX_CNTL_BITS'(i)) begin
                m_axis_tdata = bram_din[i*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    assign row_complete = &fill;

    // Uses the mask before this edge's restart.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            underfill_err <= 1'b0;
        end else if (bram_wen && !row_complete) begin
            underfill_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_bram_adapter_v1_0_rowbuf.sv
module tb_axis_bram_adapter_v1_0_rowbuf;

    localparam int N = 36;
    localparam int W = 16;
    localparam int S = 6;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic [2*N-1:0] mux = '0;
    logic [S-1:0]   sel = '0;
    logic           wen = 1'b0;
    logic [W-1:0]   tdata = '0;
    logic           tvalid = 1'b0;
    logic [N*W-1:0] dout = '0;
    logic [N*W-1:0] din;
    logic [W-1:0]   mdata;
    logic           rc;
    logic           uerr;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] sb[$];

    always #5 clk = ~clk;

    axis_bram_adapter_v1_0_rowbuf #(
        .WORD_WIDTH            (W),
        .BRAM_WIDTH_IN_WORD    (N),
        .TO_AXIS_MUX_CNTL_BITS (S)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .from_axis_mux_cntl (mux),
        .to_axis_mux_cntl   (sel),
        .bram_wen           (wen),
        .s_axis_tdata       (tdata),
        .s_axis_tvalid      (tvalid),
        .bram_dout          (dout),
        .bram_din           (din),
        .m_axis_tdata       (mdata),
        .row_complete       (rc),
        .underfill_err      (uerr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream word i in with the given valid; expectation queued when driven.
    task automatic load_word(input int i, input logic [W-1:0] d, input logic v);
        mux = '0;
        mux[2*i +: 2] = 2'b11;
        tdata = d;
        tvalid = v;
        sb.push_back(d);
        tick();
        mux = '0;
        tvalid = 1'b0;
    endtask

    task automatic test_reset();
        sel = 6'd5;
        #3;
        n_cmp++;
        if (rc !== 1'b0 || din !== '0 || mdata !== '0 || uerr !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: rc=%b uerr=%b mdata=%h required all 0", rc, uerr, mdata);
        end
        tick();
        rstn = 1'b1;
        tick();
        n_cmp++;
        if (mdata !== 16'h0 || din !== '0 || rc !== 1'b0 || uerr !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: mdata=%h rc=%b uerr=%b required 0/0/0", mdata, rc, uerr);
        end
    endtask

    task automatic test_write_row();
        logic [W-1:0] e;
        for (int i = 0; i < N; i++) load_word(i, 16'(16'h100 + i), 1'b1);
        n_cmp++;
        if (rc !== 1'b1) begin
            n_err++;
            $display("FAIL write_row_complete: got %b required 1", rc);
        end
        for (int i = 0; i < N; i++) begin
            e = sb.pop_front();
            n_cmp++;
            if (din[i*W +: W] !== e) begin
                n_err++;
                $display("FAIL write_row_word%0d: got %h required %h", i, din[i*W +: W], e);
            end
        end
        sel = 6'd35;
        #1;
        n_cmp++;
        if (mdata !== 16'h0123) begin
            n_err++;
            $display("FAIL write_row_sel35: got %h required 0123", mdata);
        end
        wen = 1'b1;
        tick();
        wen = 1'b0;
        n_cmp++;
        if (uerr !== 1'b0 || rc !== 1'b0) begin
            n_err++;
            $display("FAIL write_row_wen: uerr=%b rc=%b required 0/0", uerr, rc);
        end
    endtask

    task automatic test_underfill();
        for (int i = 0; i < 10; i++) load_word(i, 16'(16'h200 + i), 1'b1);
        sb.delete();
        wen = 1'b1;
        tick();
        wen = 1'b0;
        n_cmp++;
        if (uerr !== 1'b1) begin
            n_err++;
            $display("FAIL underfill_set: got %b required 1", uerr);
        end
        repeat (10) tick();
        n_cmp++;
        if (uerr !== 1'b1 || rc !== 1'b0) begin
            n_err++;
            $display("FAIL underfill_sticky: uerr=%b rc=%b required 1/0", uerr, rc);
        end
    endtask

    task automatic test_read_row();
        logic [W-1:0] e;
        for (int i = 0; i < N; i++) dout[i*W +: W] = 16'(16'hA000 + i);
        mux = {N{2'b10}};
        tick();
        mux = '0;
        dout = '1;  // later BRAM activity must not leak into the held row
        for (int i = 0; i < N; i++) sb.push_back(16'(16'hA000 + i));
        n_cmp++;
        if (rc !== 1'b1) begin
            n_err++;
            $display("FAIL read_row_complete: got %b required 1", rc);
        end
        for (int i = 0; i < N; i++) begin
            sel = S'(i);
            #1;
            e = sb.pop_front();
            n_cmp++;
            if (mdata !== e) begin
                n_err++;
                $display("FAIL read_row_sel%0d: got %h required %h", i, mdata, e);
            end
        end
        sel = 6'd40;
        #1;
        n_cmp++;
        if (mdata !== 16'h0) begin
            n_err++;
            $display("FAIL read_row_sel40: got %h required 0000", mdata);
        end
        tick();
    endtask

    task automatic test_stall();
        logic [W-1:0] e;
        load_word(3, 16'hDEAD, 1'b0);
        e = sb.pop_front();
        n_cmp++;
        if (din[3*W +: W] !== e || rc !== 1'b0) begin
            n_err++;
            $display("FAIL stall_invalid: word3=%h rc=%b required %h/0", din[3*W +: W], rc, e);
        end
        load_word(3, 16'hBEEF, 1'b1);
        e = sb.pop_front();
        n_cmp++;
        if (din[3*W +: W] !== e || rc !== 1'b1) begin
            n_err++;
            $display("FAIL stall_valid: word3=%h rc=%b required %h/1", din[3*W +: W], rc, e);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 18; i++) load_word(i, 16'(16'h300 + i), 1'b1);
        sb.delete();
        sel = 6'd2;
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if (din !== '0 || mdata !== 16'h0 || rc !== 1'b0 || uerr !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: mdata=%h rc=%b uerr=%b required 0/0/0", mdata, rc, uerr);
        end
        tick();
        rstn = 1'b1;
        // Only the back half is loaded; a stale mask would report completion.
        for (int i = 18; i < N; i++) load_word(i, 16'(16'h400 + i), 1'b1);
        sb.delete();
        n_cmp++;
        if (rc !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset_mask: rc=%b required 0", rc);
        end
        for (int i = 0; i < 18; i++) load_word(i, 16'(16'h500 + i), 1'b1);
        sb.delete();
        n_cmp++;
        if (rc !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset_refill: rc=%b required 1", rc);
        end
    endtask

    initial begin
        test_reset();
        test_write_row();
        test_underfill();
        test_read_row();
        test_stall();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
